sound_player: RTL and testbench

SOUND_PLAYER -- requirements
Module: sound_player

---
 rtl/sound_pkg.sv | 12 +
 rtl/sound_pwm.sv | 24 ++
 rtl/sound_player.sv | 100 ++++++++++
 tb/tb_sound_player.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the sample player: FSM state encoding and default widths.
package sound_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 16;
  localparam int DIV_W_DEF  = 16;
  localparam int VOL_W_DEF  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;
endpackage

// File: rtl/sound_pwm.sv
// Free-running PWM: the duty only reloads at the end of a period so no period is cut short.
module sound_pwm #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] level,
  output logic              pwm
);
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      cnt <= cnt + DATA_W'(1);
      if (&cnt) duty <= level;
      pwm <= (cnt < duty);
    end
  end
endmodule

// File: rtl/sound_player.sv
// Streams samples from memory at a programmable rate, scales by volume and drives PWM audio.
module sound_player
  import sound_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int VOL_W  = VOL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [DIV_W-1:0]  div,
  input  logic [ADDR_W-1:0] last,
  input  logic [VOL_W-1:0]  vol,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pwm,
  output logic              busy,
  output logic              done
);
  state_t                   state, state_nx;
  logic [ADDR_W-1:0]        addr;
  logic [DIV_W-1:0]         div_cnt;
  logic                     rd_en_q;
  logic [DATA_W-1:0]        sample_q;
  logic [DATA_W+VOL_W-1:0]  prod;
  logic [DATA_W-1:0]        scaled;
  logic                     tick;
  logic                     at_last;

  assign tick    = (div_cnt == div);
  assign at_last = (addr == last);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && !stop) state_nx = PLAY;
      PLAY: begin
        if (stop)                         state_nx = IDLE;
        else if (tick && at_last && !loop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == PLAY);
    rd_en   = (state == PLAY) && (div_cnt == '0);
    rd_addr = addr;
  end

  // Address/divider return to 0 whenever playback is not advancing, so a new start is clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      div_cnt  <= '0;
      done     <= 1'b0;
      rd_en_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      done    <= 1'b0;
      rd_en_q <= rd_en;
      if (rd_en_q) sample_q <= rd_data;
      if (state != PLAY || stop) begin
        addr    <= '0;
        div_cnt <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        if (at_last) begin
          addr <= '0;
          if (!loop) done <= 1'b1;
        end else begin
          addr <= addr + ADDR_W'(1);
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Full-width product, then drop VOL_W bits: max volume is just below unity.
  assign prod   = {{VOL_W{1'b0}}, sample_q} * {{DATA_W{1'b0}}, vol};
  assign scaled = prod[DATA_W+VOL_W-1:VOL_W];

  sound_pwm #(.DATA_W(DATA_W)) u_pwm (
    .clk   (clk),
    .rst   (rst),
    .level (busy ? scaled : '0),
    .pwm   (pwm)
  );
endmodule

// File: tb/tb_sound_player.sv
// Randomised and directed checks of sound_player against a time-based playback model.
module tb_sound_player;
  logic        clk = 1'b0;
  logic        rst, start, stop, loop;
  logic [15:0] div, last;
  logic [3:0]  vol;
  logic        rd_en, pwm, busy, done;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;

  int  checks = 0, errors = 0;
  bit  armed = 0, const_mode = 0;

  // model state: playback is "t cycles since entry"; everything else derives from t
  bit  m_play = 0, m_done = 0, m_pend = 0, m_pwm = 0;
  int  m_t = 0, m_sq = 0, m_pdata = 0, m_cnt = 0, m_duty = 0;

  always #5 clk = ~clk;

  sound_player dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop), .div(div),
    .last(last), .vol(vol), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pwm(pwm), .busy(busy), .done(done)
  );

  function automatic int mem_val(input int a);
    return const_mode ? 'h80 : ((32'h40 * (a + 1)) & 'hFF);
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= 8'(mem_val(int'(rd_addr)));

  function automatic int m_addr();
    return m_play ? (m_t / (int'(div) + 1)) % (int'(last) + 1) : 0;
  endfunction
  function automatic bit m_rden();
    return m_play && (m_t % (int'(div) + 1) == 0);
  endfunction

  always @(posedge clk) begin
    bit rde, tk;
    int idx;
    if (rst) begin
      m_play = 0; m_t = 0; m_pend = 0; m_sq = 0; m_cnt = 0;
      m_duty = 0; m_pwm = 0; m_done = 0;
    end else begin
      rde = m_rden();
      idx = m_t / (int'(div) + 1);
      tk  = m_play && (m_t % (int'(div) + 1) == int'(div));
      m_pwm = (m_cnt < m_duty);
      if (m_cnt == 255) m_duty = m_play ? (m_sq * int'(vol)) / 16 : 0;
      m_cnt = (m_cnt + 1) % 256;
      if (m_pend) m_sq = m_pdata;
      m_pend  = rde;
      m_pdata = mem_val(m_addr());
      m_done  = 0;
      if (m_play) begin
        if (stop) m_play = 0;
        else if (tk && (idx % (int'(last) + 1)) == int'(last) && !loop) begin
          m_play = 0; m_done = 1;
        end else m_t++;
      end else if (start && !stop) begin
        m_play = 1; m_t = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (armed) begin
    chk("busy", int'(busy), int'(m_play));
    chk("rd_en", int'(rd_en), int'(m_rden()));
    chk("rd_addr", int'(rd_addr), m_addr());
    chk("done", int'(done), int'(m_done));
    chk("pwm", int'(pwm), int'(m_pwm));
  end

  task automatic all_zero(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_rd_en"}, int'(rd_en), 0);
    chk({name, "_rd_addr"}, int'(rd_addr), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_pwm"}, int'(pwm), 0);
  endtask

  // start pulse, then record read addresses until done (bounded)
  task automatic run_oneshot(input string name, input int exp_len, input int n_rd);
    int k = 0;
    int q[$];
    start = 1; @(negedge clk); start = 0;
    while (!done && k < 200) begin
      if (rd_en) q.push_back(int'(rd_addr));
      @(negedge clk); k++;
    end
    chk({name, "_done_cycle"}, k, exp_len);
    chk({name, "_busy_after"}, int'(busy), 0);
    chk({name, "_nreads"}, q.size(), n_rd);
    foreach (q[i]) chk({name, "_addr"}, q[i], i);
  endtask

  task automatic wait_rd(input int a, input string name);
    int k = 0;
    while (!(rd_en && rd_addr == 16'(a)) && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) chk({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    int hi;
    rst = 1; start = 0; stop = 0; loop = 0; div = 3; last = 3; vol = 15;
    repeat (3) @(negedge clk);
    armed = 1;
    all_zero("reset");
    rst = 0;
    @(negedge clk);

    run_oneshot("oneshot", 16, 4);
    repeat (3) @(negedge clk);

    div = 0; last = 0;
    run_oneshot("single", 1, 1);
    div = 3; last = 3;

    // looping: addresses keep cycling, no done
    loop = 1; start = 1; @(negedge clk); start = 0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (rd_en) begin chk("loop_addr", int'(rd_addr), hi % 4); hi++; end
      chk("loop_nodone", int'(done), 0);
      @(negedge clk);
    end
    stop = 1; @(negedge clk); stop = 0;
    chk("stop_idle", int'(busy), 0);

    // constant 0x80 at vol 8 gives duty 0x40: 64 high cycles per 256
    const_mode = 1; vol = 8; start = 1; @(negedge clk); start = 0;
    repeat (600) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 256; i++) begin hi += int'(pwm); @(negedge clk); end
    chk("pwm_duty64", hi, 64);
    stop = 1; @(negedge clk); stop = 0;
    repeat (520) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 256; i++) begin hi += int'(pwm); @(negedge clk); end
    chk("pwm_off_after_stop", hi, 0);
    const_mode = 0; vol = 15;

    // stop coinciding with the final tick of a one-shot
    loop = 0; start = 1; @(negedge clk); start = 0;
    wait_rd(3, "stop_tick");
    repeat (3) @(negedge clk);
    stop = 1; @(negedge clk); stop = 0;
    chk("stoptick_busy", int'(busy), 0);
    chk("stoptick_done", int'(done), 0);
    @(negedge clk);
    chk("stoptick_done2", int'(done), 0);

    // reset mid-play, then restart from 0
    loop = 1; start = 1; @(negedge clk); start = 0;
    wait_rd(2, "rst_mid");
    rst = 1; @(negedge clk);
    all_zero("rst_mid");
    rst = 0; start = 1; @(negedge clk); start = 0;
    chk("restart_rd_en", int'(rd_en), 1);
    chk("restart_addr", int'(rd_addr), 0);
    stop = 1; @(negedge clk); stop = 0;

    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 699) == 0);
      if (!m_play) begin
        div  = 16'($urandom_range(0, 3));
        last = 16'($urandom_range(0, 5));
        loop = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) vol = 4'($urandom);
      @(negedge clk);
    end
    rst = 0; start = 0; stop = 0;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
